// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: IF SRAM-like fetch port to single-beat in-order AXI4 reads on AR/R.
// Defining INST_AXI_PERF_CNT_EN adds the perf_stall_cnt/perf_fetch_cnt counters.
module inst_axi_rd_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AR_ID           = 4'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
`ifdef INST_AXI_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_fetch_cnt,
`endif
    output logic        rready
);
    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_BUSY = 1'b1;
    logic [0:0] state;
    logic [2:0] cnt;
    logic [1:0] size_q;
    logic       r_done;
    logic       unused_ok;
    assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};
    // Only the registered count gates acceptance; a same-cycle rlast does not free a slot.
    assign inst_sram_addr_ok = resetn & (state == AR_IDLE) & inst_sram_req & ~inst_sram_wr
                             & (cnt < 3'(MAX_OUTSTANDING));
    assign rready            = resetn;
    assign r_done            = rvalid & rready & rlast;
    assign inst_sram_data_ok = r_done;
    assign inst_sram_rdata   = rdata;
    assign arvalid           = (state == AR_BUSY);
    assign arid              = AR_ID;
    assign arlen             = 8'h00;
    assign arsize            = {1'b0, size_q};
    assign arburst           = 2'b01;
    assign arlock            = 2'b00;
    assign arcache           = 4'h0;
    assign arprot            = 3'h0;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= AR_IDLE;
            araddr <= '0;
            size_q <= '0;
        end else if (state == AR_IDLE) begin
            if (inst_sram_addr_ok) begin
                state  <= AR_BUSY;
                araddr <= inst_sram_addr;
                size_q <= inst_sram_size;
            end
        end else if (arready) begin
            state <= AR_IDLE;
        end
    end
    // A stray completion with nothing outstanding must not wrap the counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (inst_sram_addr_ok && !r_done)
            cnt <= cnt + 3'd1;
        else if (!inst_sram_addr_ok && r_done && cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end
`ifdef INST_AXI_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt <= '0;
            perf_fetch_cnt <= '0;
        end else begin
            if (inst_sram_req && !inst_sram_wr && !inst_sram_addr_ok)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (r_done)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb_inst_axi_rd_bridge: scoreboard bench for inst_axi_rd_bridge with a small in-order AXI read slave.
module tb_inst_axi_rd_bridge;
    logic        clk, resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
`ifdef INST_AXI_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_fetch_cnt;
`endif
    logic        s_rv, m_rv, r_go, s_hs, s_beat;
    logic [31:0] s_data, m_data;
    int          ret;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [34:0] exp_ar[$];
    logic [31:0] exp_r[$];
    logic [31:0] sdata[$];

    assign rvalid = s_rv | m_rv;
    assign rdata  = m_rv ? m_data : s_data;
    assign rresp  = m_rv ? 2'b10 : 2'b00;

    inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AR_ID(4'h0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
        .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(inst_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(4'h0), .rdata(rdata), .rresp(rresp), .rlast(1'b1), .rvalid(rvalid),
`ifdef INST_AXI_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_fetch_cnt(perf_fetch_cnt),
`endif
        .rready(rready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        exp_ar.push_back({sz, a});
        exp_r.push_back(d);
        sdata.push_back(d);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_r.size() != 0 || exp_ar.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check(nm, 64'(exp_r.size() + exp_ar.size()), 0);
    endtask

    // In-order slave: one beat per accepted AR, earliest the cycle after the handshake.
    initial begin
        s_rv = 0;
        s_data = 0;
        ret = 0;
        forever begin
            @(negedge clk);
            s_hs = arvalid && arready;
            s_beat = s_rv && rready;
            @(posedge clk);
            #2;
            if (!resetn) begin
                s_rv = 0;
                ret = 0;
                sdata.delete();
            end else begin
                if (s_hs) ret++;
                if (s_beat) begin
                    s_rv = 0;
                    ret--;
                    void'(sdata.pop_front());
                end
                if (!s_rv && r_go && ret > 0 && sdata.size() > 0) begin
                    s_rv = 1;
                    s_data = sdata[0];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (data_ok) begin
                    if (exp_r.size() == 0) check("data_ok_unexpected", data_ok, 0);
                    else check("rdata", inst_rdata, exp_r.pop_front());
                end
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) check("ar_unexpected", arvalid, 0);
                    else check("ar_addr_size", {arsize, araddr}, exp_ar.pop_front());
                    check("ar_fixed", {arid, arlen, arburst, arlock, arcache, arprot},
                          {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
                end
            end
        end
    end

    initial begin
        resetn = 0; req = 1; wr = 0; size = 2; addr = 0; wstrb = 0; wdata = 0;
        arready = 0; r_go = 0; m_rv = 0; m_data = 0;
        repeat (2) tick();
        smp();
        check("rst_arvalid", arvalid, 0);
        check("rst_addr_ok", addr_ok, 0);
        check("rst_data_ok", data_ok, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        tick(); resetn = 1; req = 0;
        tick(); check("rready_on", rready, 1);
        // single fetch
        arready = 1; r_go = 1;
        tick(); req = 1; addr = 32'h1c000000; size = 2;
        smp(); check("t1_addr_ok", addr_ok, 1); push(32'h1c000000, 3'd2, 32'h02800c0c);
        tick(); req = 0;
        smp(); check("t1_arvalid", arvalid, 1); check("t1_araddr", araddr, 32'h1c000000);
        tick();
        smp(); check("t1_data_ok", data_ok, 1);
        drain("t1_drain");
        // write requests are never accepted
        tick(); req = 1; wr = 1; addr = 32'h1c000100;
        repeat (3) begin
            smp(); check("wr_blocked", addr_ok, 0);
            tick();
        end
        req = 0; wr = 0;
        // stray beat with nothing outstanding; error response still passes
        m_rv = 1; m_data = 32'hdeadbeef; exp_r.push_back(32'hdeadbeef);
        smp(); check("spur_data_ok", data_ok, 1);
        tick(); m_rv = 0;
        // outstanding limit with R stalled
        r_go = 0; arready = 1;
        req = 1; addr = 32'h1c000010;
        smp(); check("t3_accept_a", addr_ok, 1); push(32'h1c000010, 3'd2, 32'h11111111);
        tick(); addr = 32'h1c000014;
        smp(); check("t3_busy", addr_ok, 0);
        tick();
        smp(); check("t3_accept_b", addr_ok, 1); push(32'h1c000014, 3'd2, 32'h22222222);
        tick(); addr = 32'h1c000018;
        tick();
        smp(); check("t3_full", addr_ok, 0);
        tick();
        smp(); check("t3_full_hold", addr_ok, 0);
        tick(); r_go = 1;
        smp(); check("t3_rlast_a", data_ok, 1); check("t3_same_cycle_blocked", addr_ok, 0);
        tick();
        smp(); check("t4_accept", addr_ok, 1); check("t4_data_ok", data_ok, 1);
        push(32'h1c000018, 3'd2, 32'h33333333);
        tick(); req = 0; r_go = 0;
        tick(); req = 1; addr = 32'h1c00001c; arready = 0;
        smp(); check("t4_cnt_one", addr_ok, 1); push(32'h1c00001c, 3'd2, 32'h44444444);
        tick(); req = 0;
        smp(); check("t5_pre_arvalid", arvalid, 1);
        // asynchronous reset mid-transaction
        #2; resetn = 0; req = 1;
        #1;
        check("t5_arvalid", arvalid, 0);
        check("t5_addr_ok", addr_ok, 0);
        check("t5_rready", rready, 0);
        check("t5_araddr", araddr, 0);
        req = 0;
        exp_ar.delete(); exp_r.delete();
        tick(); tick(); resetn = 1;
        // held AR plus stall/fetch counting from a clean reset
        arready = 0; r_go = 1; req = 1; addr = 32'h80001000; size = 1;
        smp(); check("t2_accept", addr_ok, 1); push(32'h80001000, 3'd1, 32'h55aa00ff);
        tick(); addr = 32'h1c000040; size = 2;
        repeat (3) begin
            smp();
            check("t2_arvalid", arvalid, 1);
            check("t2_araddr", araddr, 32'h80001000);
            check("t2_arsize", arsize, 3'd1);
            check("t2_addr_ok", addr_ok, 0);
            tick();
        end
        arready = 1;
        smp(); check("t2_busy_last", addr_ok, 0);
        tick();
        smp(); check("t2_accept_b", addr_ok, 1); push(32'h1c000040, 3'd2, 32'h0badf00d);
        tick(); req = 0;
        drain("t2_drain");
`ifdef INST_AXI_PERF_CNT_EN
        smp();
        check("perf_stall", perf_stall_cnt, 4);
        check("perf_fetch", perf_fetch_cnt, 2);
`endif
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
